// File: rtl/bird_physics_engine.sv
//------------------------------------------------------------------------------
// Module      : bird_physics_engine
// Description : Per-frame gravity/flap bird physics with an erase/draw pixel
//               sequencer feeding the plot arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bird_physics_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int V_W      = 5,
  parameter int BIRD_X   = 20,
  parameter int BIRD_W   = 4,
  parameter int BIRD_H   = 4,
  parameter int Y_START  = 58,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 119,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = 4,
  parameter int MAX_FALL = 6,
  parameter int COLOUR_W = 3,
  parameter logic [COLOUR_W-1:0] BIRD_COLOUR = 3'b010,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                flap,
  input  logic                restart,
  input  logic                pix_ready,
  output logic                pix_valid,
  output logic [X_W-1:0]      pix_x,
  output logic [Y_W-1:0]      pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  output logic [Y_W-1:0]      bird_y,
  output logic [V_W-1:0]      bird_vel,
  output logic                crashed,
  output logic                busy,
  output logic                overrun
);

  localparam int c_DX_W = (BIRD_W > 1) ? $clog2(BIRD_W) : 1;
  localparam int c_DY_W = (BIRD_H > 1) ? $clog2(BIRD_H) : 1;
  localparam int c_S_W  = Y_W + 2;

  localparam logic [c_DX_W-1:0]        c_DX_LAST  = c_DX_W'(BIRD_W - 1);
  localparam logic [c_DY_W-1:0]        c_DY_LAST  = c_DY_W'(BIRD_H - 1);
  localparam logic signed [c_S_W-1:0]  c_GRAVITY  = c_S_W'(GRAVITY);
  localparam logic signed [c_S_W-1:0]  c_FLAP_V   = c_S_W'(-FLAP_VEL);
  localparam logic signed [c_S_W-1:0]  c_MAX_FALL = c_S_W'(MAX_FALL);
  localparam logic signed [c_S_W-1:0]  c_Y_MIN    = c_S_W'(Y_MIN);
  localparam logic signed [c_S_W-1:0]  c_Y_FLOOR  = c_S_W'(Y_MAX - BIRD_H + 1);

  typedef enum logic [2:0] {
    SPAWN_DRAW = 3'd0,
    IDLE       = 3'd1,
    ERASE      = 3'd2,
    UPDATE     = 3'd3,
    DRAW       = 3'd4,
    DEAD       = 3'd5,
    RS_ERASE   = 3'd6
  } state_t;

  state_t r_state, w_state_next;

  logic [Y_W-1:0]    r_bird_y;
  logic [V_W-1:0]    r_bird_vel;
  logic              r_crashed;
  logic              r_overrun;
  logic              r_flap_pend;
  logic              r_flap_prev;
  logic              r_floor_hit;
  logic [c_DX_W-1:0] r_dx;
  logic [c_DY_W-1:0] r_dy;

  logic              w_seq_state;
  logic              w_beat;
  logic              w_last_beat;
  logic              w_flap_rise;

  logic signed [c_S_W-1:0] w_vel_ext;
  logic signed [c_S_W-1:0] w_vel_grav;
  logic signed [c_S_W-1:0] w_vel_new;
  logic signed [c_S_W-1:0] w_y_new;

  assign w_seq_state = (r_state == SPAWN_DRAW) || (r_state == ERASE) ||
                       (r_state == DRAW)       || (r_state == RS_ERASE);
  assign w_beat      = w_seq_state && pix_ready;
  assign w_last_beat = w_beat && (r_dx == c_DX_LAST) && (r_dy == c_DY_LAST);
  assign w_flap_rise = flap && !r_flap_prev;

  assign pix_valid = w_seq_state;
  assign pix_x     = X_W'(BIRD_X) + X_W'(r_dx);
  assign pix_y     = r_bird_y + Y_W'(r_dy);
  assign bird_y    = r_bird_y;
  assign bird_vel  = r_bird_vel;
  assign crashed   = r_crashed;
  assign overrun   = r_overrun;

  // Physics evaluated at two extra bits so under/overflow past the screen edges is visible
  assign w_vel_ext  = {{(c_S_W - V_W){r_bird_vel[V_W-1]}}, r_bird_vel};
  assign w_vel_grav = w_vel_ext + c_GRAVITY;
  assign w_vel_new  = r_flap_pend ? c_FLAP_V :
                      ((w_vel_grav > c_MAX_FALL) ? c_MAX_FALL : w_vel_grav);
  assign w_y_new    = $signed({2'b00, r_bird_y}) + w_vel_new;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= SPAWN_DRAW;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    pix_colour   = BIRD_COLOUR;
    busy         = 1'b1;
    case (r_state)
      SPAWN_DRAW: if (w_last_beat) w_state_next = IDLE;
      IDLE: begin
        busy = 1'b0;
        if (frame_tick) w_state_next = ERASE;
      end
      ERASE: begin
        pix_colour = BG_COLOUR;
        if (w_last_beat) w_state_next = UPDATE;
      end
      UPDATE:     w_state_next = DRAW;
      DRAW:       if (w_last_beat) w_state_next = r_floor_hit ? DEAD : IDLE;
      DEAD: begin
        busy = 1'b0;
        if (restart) w_state_next = RS_ERASE;
      end
      RS_ERASE: begin
        pix_colour = BG_COLOUR;
        if (w_last_beat) w_state_next = SPAWN_DRAW;
      end
      default:    w_state_next = SPAWN_DRAW;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bird_y    <= Y_W'(Y_START);
      r_bird_vel  <= '0;
      r_crashed   <= 1'b0;
      r_overrun   <= 1'b0;
      r_flap_pend <= 1'b0;
      r_flap_prev <= 1'b0;
      r_floor_hit <= 1'b0;
      r_dx        <= '0;
      r_dy        <= '0;
    end else begin
      r_flap_prev <= flap;

      // An edge landing on the UPDATE cycle survives into the next frame
      if (r_state == UPDATE)
        r_flap_pend <= w_flap_rise;
      else if (w_flap_rise && (r_state != DEAD))
        r_flap_pend <= 1'b1;

      if (frame_tick && busy)
        r_overrun <= 1'b1;

      if (w_beat) begin
        if (r_dx == c_DX_LAST) begin
          r_dx <= '0;
          if (r_dy == c_DY_LAST) r_dy <= '0;
          else                   r_dy <= r_dy + 1'b1;
        end else begin
          r_dx <= r_dx + 1'b1;
        end
      end

      if (r_state == UPDATE) begin
        if (w_y_new < c_Y_MIN) begin
          r_bird_y    <= Y_W'(Y_MIN);
          r_bird_vel  <= '0;
          r_floor_hit <= 1'b0;
        end else if (w_y_new > c_Y_FLOOR) begin
          r_bird_y    <= c_Y_FLOOR[Y_W-1:0];
          r_bird_vel  <= '0;
          r_floor_hit <= 1'b1;
        end else begin
          r_bird_y    <= w_y_new[Y_W-1:0];
          r_bird_vel  <= w_vel_new[V_W-1:0];
          r_floor_hit <= 1'b0;
        end
      end

      if ((r_state == DRAW) && w_last_beat && r_floor_hit) begin
        r_crashed   <= 1'b1;
        r_floor_hit <= 1'b0;
      end

      if ((r_state == RS_ERASE) && w_last_beat) begin
        r_bird_y    <= Y_W'(Y_START);
        r_bird_vel  <= '0;
        r_crashed   <= 1'b0;
        r_flap_pend <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bird_physics_engine.sv
//------------------------------------------------------------------------------
// Module      : tb_bird_physics_engine
// Description : Randomised frame/flap/back-pressure bench with a frame-level
//               bird model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bird_physics_engine;

  logic       clk = 1'b0;
  logic       reset, frame_tick, flap, restart, pix_ready;
  logic       pix_valid;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic [6:0] bird_y;
  logic [4:0] bird_vel;
  logic       crashed, busy, overrun;

  int n_checks = 0;
  int n_errors = 0;
  int beats[$];

  // Frame-level model of the bird
  int m_y, m_vel;
  bit m_dead, m_pend, m_flap_prev, m_overrun;

  always #5 clk = ~clk;

  bird_physics_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .flap(flap),
    .restart(restart), .pix_ready(pix_ready), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .bird_y(bird_y),
    .bird_vel(bird_vel), .crashed(crashed), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_beat(input int i, input int y, input int col);
    return ((20 + i % 4) << 10) | ((y + i / 4) << 3) | col;
  endfunction

  // Back-pressure: ready changes just after each rising edge
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 pix_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Beat capture and stall-stability monitor
  initial begin
    bit p_stall;
    int p_beat, cur;
    p_stall = 1'b0;
    p_beat  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_stall = 1'b0;
      end else begin
        cur = {pix_x, pix_y, pix_colour};
        if (p_stall) check("stall_hold", pix_valid ? cur : -1, p_beat);
        p_stall = pix_valid && !pix_ready;
        p_beat  = cur;
        if (pix_valid && pix_ready) beats.push_back(cur);
      end
    end
  end

  task automatic wait_done(input int tick_at);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      frame_tick = (k == tick_at);
      restart    = 1'b0;
      if (!busy) done = 1'b1;
    end
    if (!done) check("timeout", 0, 1);
  endtask

  task automatic check_beats(input string tag, input int y0, input int c0,
                             input int y1, input int c1, input int n);
    check({tag, "_count"}, beats.size(), n);
    for (int i = 0; i < n && i < beats.size(); i++)
      check({tag, "_beat"}, beats[i],
            (i < 16) ? exp_beat(i, y0, c0) : exp_beat(i - 16, y1, c1));
  endtask

  task automatic check_state(input string tag);
    check({tag, "_y"},       int'(bird_y), m_y);
    check({tag, "_vel"},     int'($signed(bird_vel)), m_vel);
    check({tag, "_crashed"}, int'(crashed), int'(m_dead));
    check({tag, "_overrun"}, int'(overrun), int'(m_overrun));
    check({tag, "_busy"},    int'(busy), 0);
  endtask

  task automatic do_frame(input bit fl, input int tick_at);
    int y0, v;
    @(negedge clk);
    flap = fl;
    if (!m_dead && fl && !m_flap_prev) m_pend = 1'b1;
    m_flap_prev = fl;
    @(negedge clk);
    beats.delete();
    frame_tick = 1'b1;
    if (m_dead) begin
      repeat (8) begin
        @(negedge clk);
        frame_tick = 1'b0;
      end
      check("dead_beats", beats.size(), 0);
      check_state("dead");
      return;
    end
    y0 = m_y;
    v  = m_pend ? -4 : ((m_vel + 1 > 6) ? 6 : m_vel + 1);
    m_pend = 1'b0;
    m_y = m_y + v;
    m_vel = v;
    if (m_y < 0) begin
      m_y = 0; m_vel = 0;
    end else if (m_y > 116) begin
      m_y = 116; m_vel = 0; m_dead = 1'b1;
    end
    if (tick_at >= 0) m_overrun = 1'b1;
    wait_done(tick_at);
    check_beats("frame", y0, 0, m_y, 2, 32);
    check_state("frame");
  endtask

  task automatic do_restart();
    int y0;
    @(negedge clk);
    beats.delete();
    restart = 1'b1;
    y0 = m_y;
    m_y = 58; m_vel = 0; m_dead = 1'b0; m_pend = 1'b0;
    wait_done(-1);
    check_beats("restart", y0, 0, 58, 2, 32);
    check_state("restart");
  endtask

  task automatic spawn_after_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    beats.delete();
    @(negedge clk);
    check("valid_after_reset", int'(pix_valid), 1);
    wait_done(-1);
    check_beats("spawn", 58, 2, 0, 0, 16);
    check_state("spawn");
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; flap = 1'b0; restart = 1'b0;
    m_y = 58; m_vel = 0; m_dead = 1'b0; m_pend = 1'b0;
    m_flap_prev = 1'b0; m_overrun = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_y", int'(bird_y), 58);
    check("rst_vel", int'(bird_vel), 0);
    check("rst_crashed", int'(crashed), 0);
    check("rst_overrun", int'(overrun), 0);
    spawn_after_reset();

    // Randomised flight with crash/restart handling
    for (int f = 0; f < 40; f++) begin
      do_frame(m_flap_prev ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0), -1);
      if (m_dead) begin
        do_frame(bit'($urandom_range(0, 1)), -1);
        do_restart();
      end
    end

    // Guaranteed floor crash
    for (int f = 0; f < 40 && !m_dead; f++) do_frame(1'b0, -1);
    check("forced_crash", int'(m_dead), 1);
    do_frame(1'b0, -1);
    do_restart();

    // Restart outside DEAD is ignored
    @(negedge clk);
    beats.delete();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (4) @(negedge clk);
    check("restart_ignored_beats", beats.size(), 0);
    check_state("restart_ignored");

    // Extra tick mid-sequence: ignored but sets sticky overrun
    do_frame(1'b0, 20);
    do_frame(1'b1, -1);

    // Asynchronous reset in the middle of ERASE
    @(negedge clk);
    flap = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_erase_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_y", int'(bird_y), 58);
    check("arst_vel", int'(bird_vel), 0);
    check("arst_overrun", int'(overrun), 0);
    check("arst_pix_x", int'(pix_x), 20);
    check("arst_pix_y", int'(pix_y), 58);
    m_y = 58; m_vel = 0; m_dead = 1'b0; m_pend = 1'b0;
    m_flap_prev = 1'b0; m_overrun = 1'b0;
    spawn_after_reset();
    for (int f = 0; f < 3; f++) do_frame(1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
